// File: rtl/rs_subtractor_seq.sv
// Bit-serial ripple-borrow subtractor: {borrow, A-B-Bin} computed LSB first with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining RS_SUB_OVF_EN.
module rs_subtractor_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH:0]   diff,
  output logic             busy,
  output logic             done
`ifdef RS_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             a_i, b_i, d_bit, br_next, last_bit;
`ifdef RS_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  // Full-subtractor cell for the current bit
  assign a_i      = a_sh[0];
  assign b_i      = b_sh[0];
  assign d_bit    = a_i ^ b_i ^ br_q;
  assign br_next  = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else if (enable)
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial datapath and held result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef RS_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (enable) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            br_q  <= Bin;
            cnt_q <= '0;
`ifdef RS_SUB_OVF_EN
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          br_q   <= br_next;
          cnt_q  <= cnt_q + CW'(1);
        end
        DONE: begin
          diff <= {br_q, res_sh};
`ifdef RS_SUB_OVF_EN
          ovf  <= (a_msb != b_msb) && (res_sh[WIDTH-1] != a_msb);
`endif
        end
        default: ;
      endcase
      done <= (state_q == DONE);
      busy <= (state_d != IDLE);
    end
  end

endmodule
